// File: rtl/tl_ul_pkg.sv
// Purpose: TileLink-UL opcodes, D-channel beat layout and the size-to-lane-mask helper.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package tl_ul_pkg;

    // A-channel request opcodes
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Source width carried in a buffered beat; the responder's SRC_W must match it.
    localparam int TL_SRC_W = 7;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          size;
        logic [TL_SRC_W-1:0] source;
        logic                denied;
        logic [31:0]         data;
        logic                corrupt;
    } tl_d_beat_t;

    // Byte lanes a naturally aligned access of 2**size bytes touches in a 32-bit word.
    function automatic logic [3:0] size_lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << addr_lo;
            3'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tl_resp_fifo2.sv
// Purpose: two-entry in-order buffer of D-channel beats between accept and response.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full blocks pushes; the head holds still until popped.
module tl_resp_fifo2
    import tl_ul_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_vld,
    input  tl_d_beat_t push_dat,
    input  logic       pop_rdy,
    output tl_d_beat_t head_dat,
    output logic       full,
    output logic       empty
);

    tl_d_beat_t slot_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_rdy && !empty;
    assign head_dat = slot_q[rd_ptr_q];

    // Slot storage, pointers and occupancy; reset drops every queued beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_ok) begin
                slot_q[wr_ptr_q] <= push_dat;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/tl_ul_mem_responder.sv
// Purpose: TL-UL Get/Put responder over a word memory (TL_RESP_MISALIGN_CHECK_EN adds alignment/mask denial).
// Latency: one cycle from A accept to D valid when no responses are queued.
// Backpressure: a_ready drops only when two responses wait; it never looks at d_ready.
module tl_ul_mem_responder
    import tl_ul_pkg::*;
#(
    parameter int                ADDR_W = 28,
    parameter int                SRC_W  = 7,
    parameter int                DEPTH  = 64,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    input  logic              a_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_sink,
    output logic              d_denied,
    output logic [31:0]       d_data,
    output logic              d_corrupt
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(4 * DEPTH);

    logic [31:0]      mem [DEPTH];
    logic             ready_q;
    logic             a_fire;
    logic             d_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             op_ok;
    logic             align_ok;
    logic             mask_ok;
    logic             legal;
    logic             is_get;
    logic             wr_en;
    tl_d_beat_t       req_beat;
    tl_d_beat_t       head_beat;

    assign a_fire = a_valid && a_ready;
    assign d_fire = d_valid && d_ready;

    // Request decode, evaluated on the cycle the request is accepted.
    assign idx      = IDX_W'((a_address - BASE) >> 2);
    assign in_range = (a_address >= BASE) && ({1'b0, a_address} < LIMIT);
    assign is_get   = (a_opcode == GET);
    assign op_ok    = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL) || is_get;
`ifdef TL_RESP_MISALIGN_CHECK_EN
    assign align_ok = (a_size == 3'd1) ? !a_address[0] :
                      (a_size == 3'd2) ? (a_address[1:0] == 2'b00) : 1'b1;
    assign mask_ok  = (a_mask == size_lane_mask(a_size, a_address[1:0]));
`else
    assign align_ok = 1'b1;
    assign mask_ok  = 1'b1;
`endif
    assign legal = in_range && (a_size <= 3'd2) && (a_param == 3'd0) && op_ok && align_ok && mask_ok;
    assign wr_en = a_fire && legal && !is_get && !a_corrupt;

    // Ready comes up on the first clock after reset release and only tracks buffer space.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign a_ready = ready_q && !fifo_full;

    // Build the response beat; Get data is the word as it stands before this edge.
    always_comb begin
        req_beat         = '0;
        req_beat.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        req_beat.size    = a_size;
        req_beat.source  = TL_SRC_W'(a_source);
        req_beat.denied  = !legal;
        req_beat.corrupt = is_get && !legal;
        req_beat.data    = (is_get && legal) ? mem[idx] : 32'h0;
    end

    // Byte-lane write at the accept edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem[idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    tl_resp_fifo2 u_resp_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (a_fire),
        .push_dat (req_beat),
        .pop_rdy  (d_fire),
        .head_dat (head_beat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign d_valid   = !fifo_empty;
    assign d_opcode  = head_beat.opcode;
    assign d_param   = 2'b00;
    assign d_size    = head_beat.size;
    assign d_source  = SRC_W'(head_beat.source);
    assign d_sink    = 1'b0;
    assign d_denied  = head_beat.denied;
    assign d_data    = head_beat.data;
    assign d_corrupt = head_beat.corrupt;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Purpose: randomized and directed checking of the TL-UL memory responder against a queue/array model.
// Latency: model expects D one cycle after an accept into an empty buffer.
// Backpressure: d_ready is randomly withheld; a_valid holds each request until accepted.
`timescale 1ns/1ps
module tb_tl_ul_mem_responder;

    localparam int          ADDR_W = 28;
    localparam int          SRC_W  = 7;
    localparam int          DEPTH  = 64;
    localparam logic [27:0] BASE   = 28'h0000400;
    localparam int          BASE_I = 'h400;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [6:0]  a_source = '0;
    logic [27:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [6:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    always #5 clock = ~clock;

    tl_ul_mem_responder #(
        .ADDR_W (ADDR_W),
        .SRC_W  (SRC_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [6:0]  src;
        logic        den;
        logic [31:0] data;
        logic        cor;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        last_rsp;
    logic [6:0]  fired_src[$];
    bit   [31:0] mdl_mem [DEPTH];
    bit          mdl_rdy = 1'b0;
    bit          last_afire = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lanes(input int size, input int lo);
        int nb;
        nb = 1 << size;
        return 4'(((1 << nb) - 1) << lo);
    endfunction

    // Apply the access rules to the request being accepted and queue the expected response.
    task automatic model_accept();
        rsp_t r;
        int   a;
        int   off;
        bit   legal;
        bit   get;
        a = int'(a_address);
        legal = (a >= BASE_I) && (a < BASE_I + 4 * DEPTH) && (a_size <= 3'd2) && (a_param == 3'd0) &&
                (a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4);
`ifdef TL_RESP_MISALIGN_CHECK_EN
        if (a_size <= 3'd2) begin
            if ((a % (1 << a_size)) != 0) legal = 1'b0;
            if (a_mask != lanes(int'(a_size), a % 4)) legal = 1'b0;
        end
`endif
        get    = (a_opcode == 3'd4);
        off    = (a - BASE_I) / 4;
        r.op   = get ? 3'd1 : 3'd0;
        r.size = a_size;
        r.src  = a_source;
        r.den  = !legal;
        r.cor  = get && !legal;
        r.data = (get && legal) ? mdl_mem[off] : 32'h0;
        if (legal && !get && !a_corrupt) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) mdl_mem[off][8*b +: 8] = a_data[8*b +: 8];
            end
        end
        exp_q.push_back(r);
    endtask

    // One clock: check outputs at the falling edge, account for handshakes, advance past the rising edge.
    task automatic step();
        rsp_t h;
        bit   af;
        bit   df;
        @(negedge clock);
        if (reset_n) begin
            chk("a_ready", a_ready, 32'(mdl_rdy && exp_q.size() < 2));
            chk("d_valid", d_valid, 32'(exp_q.size() > 0));
            if (d_valid && exp_q.size() > 0) begin
                h = exp_q[0];
                chk("d_opcode", d_opcode, h.op);
                chk("d_size", d_size, h.size);
                chk("d_source", d_source, h.src);
                chk("d_denied", d_denied, h.den);
                chk("d_data", d_data, h.data);
                chk("d_corrupt", d_corrupt, h.cor);
                chk("d_param", d_param, 0);
                chk("d_sink", d_sink, 0);
            end
        end
        af = a_valid && a_ready;
        df = d_valid && d_ready;
        if (df) begin
            last_rsp.op   = d_opcode;
            last_rsp.size = d_size;
            last_rsp.src  = d_source;
            last_rsp.den  = d_denied;
            last_rsp.data = d_data;
            last_rsp.cor  = d_corrupt;
            fired_src.push_back(d_source);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (af) model_accept();
        last_afire = af;
        @(posedge clock);
        if (reset_n) mdl_rdy = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                        input logic [27:0] addr, input logic [3:0] mask, input logic [31:0] data);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = 3'd0;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (last_afire) return;
        end
        chk("a_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        a_valid = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) step();
        step();
    endtask

    task automatic rand_req();
        int r;
        a_valid = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 19);
        a_opcode = (r < 7) ? 3'd0 : (r < 12) ? 3'd1 : (r < 18) ? 3'd4 : 3'($urandom_range(2, 7));
        a_param  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        a_size   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r == 0)      a_address = BASE - 28'($urandom_range(1, 16));
        else if (r == 1) a_address = BASE + 28'(4 * DEPTH) + 28'($urandom_range(0, 15));
        else             a_address = BASE + 28'($urandom_range(0, 4 * DEPTH - 1));
        a_mask = 4'($urandom());
        if (a_size <= 3'd2 && $urandom_range(0, 1) == 1) begin
            if (a_size == 3'd2) a_address[1:0] = 2'b00;
            if (a_size == 3'd1) a_address[0] = 1'b0;
            a_mask = lanes(int'(a_size), int'(a_address[1:0]));
        end
        a_source  = 7'($urandom());
        a_data    = $urandom();
        a_corrupt = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic exp_den;

        // Reset state
        #12;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_opcode", d_opcode, 0);
        chk("rst_d_size", d_size, 0);
        chk("rst_d_source", d_source, 0);
        chk("rst_d_denied", d_denied, 0);
        chk("rst_d_data", d_data, 0);
        chk("rst_d_corrupt", d_corrupt, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();

        // Fill memory so every later Get has a known expected word
        d_ready = 1'b1;
        for (int w = 0; w < DEPTH; w++) send(3'd0, 3'd2, 7'(w), BASE + 28'(4 * w), 4'hF, $urandom());
        drain();

        // PutFull then Get of the same word on the next cycle
        send(3'd0, 3'd2, 7'd5, BASE + 28'd8, 4'hF, 32'hDEADBEEF);
        send(3'd4, 3'd2, 7'd6, BASE + 28'd8, 4'hF, 32'h0);
        drain();
        chk("put_get_data", last_rsp.data, 32'hDEADBEEF);
        chk("put_get_src", last_rsp.src, 6);
        chk("put_get_op", last_rsp.op, 1);
        chk("put_get_den", last_rsp.den, 0);

        // PutPartial merges one lane
        send(3'd0, 3'd2, 7'd9, BASE + 28'd12, 4'hF, 32'h11223344);
        send(3'd1, 3'd2, 7'd9, BASE + 28'd12, 4'b0010, 32'h0000AB00);
        send(3'd4, 3'd2, 7'd9, BASE + 28'd12, 4'hF, 32'h0);
        drain();
        chk("partial_data", last_rsp.data, 32'h1122AB44);

        // Get just past the window
        send(3'd4, 3'd2, 7'd10, BASE + 28'(4 * DEPTH), 4'hF, 32'h0);
        drain();
        chk("oor_op", last_rsp.op, 1);
        chk("oor_den", last_rsp.den, 1);
        chk("oor_cor", last_rsp.cor, 1);
        chk("oor_data", last_rsp.data, 0);

        // Backpressure: two accepts fill the buffer, the third waits
        fired_src.delete();
        d_ready = 1'b0;
        send(3'd4, 3'd2, 7'd1, BASE, 4'hF, 32'h0);
        send(3'd4, 3'd2, 7'd2, BASE + 28'd4, 4'hF, 32'h0);
        a_source  = 7'd3;
        a_address = BASE + 28'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_a_ready_low", a_ready, 0);
            chk("bp_d_source_hold", d_source, 1);
        end
        d_ready = 1'b1;
        for (int i = 0; i < 8 && !last_afire; i++) step();
        drain();
        chk("bp_count", fired_src.size(), 3);
        if (fired_src.size() == 3) begin
            chk("bp_order0", fired_src[0], 1);
            chk("bp_order1", fired_src[1], 2);
            chk("bp_order2", fired_src[2], 3);
        end
        chk("bp_a_ready_after", a_ready, 1);

        // Full throughput with d_ready held high
        d_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(3'd4, 3'd2, 7'(20 + i), BASE + 28'(4 * i), 4'hF, 32'h0);
        chk("tput_cycles", cyc - c0, 16);
        drain();

        // Reset with two responses queued
        d_ready = 1'b0;
        send(3'd4, 3'd2, 7'd30, BASE, 4'hF, 32'h0);
        send(3'd4, 3'd2, 7'd31, BASE + 28'd4, 4'hF, 32'h0);
        a_valid = 1'b0;
        #2;
        chk("pre_rst_d_valid", d_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", d_valid, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        exp_q.delete();
        mdl_rdy = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Misaligned word Get
`ifdef TL_RESP_MISALIGN_CHECK_EN
        exp_den = 1'b1;
`else
        exp_den = 1'b0;
`endif
        send(3'd4, 3'd2, 7'd40, BASE + 28'd2, 4'hF, 32'h0);
        drain();
        chk("misalign_den", last_rsp.den, exp_den);

        // Randomized traffic with random response backpressure
        a_valid = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!a_valid || last_afire) rand_req();
            d_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
